// File: rtl/piece_stamp_writer.sv
// Stamps a latched 6x6 piece window onto the board by issuing one ready/valid write per set,
// on-screen cell. Window origin is (piece_x-1, piece_y-1); cells are scanned ly-major.
module piece_stamp_writer #(
    parameter int BOARD_WIDTH  = 10,
    parameter int BOARD_HEIGHT = 20
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [$clog2(BOARD_WIDTH)-1:0]  piece_x,
    input  logic [$clog2(BOARD_HEIGHT)-1:0] piece_y,
    input  logic [5:0][5:0]                 window,
    output logic                            wr_valid,
    output logic [$clog2(BOARD_WIDTH)-1:0]  wr_x,
    output logic [$clog2(BOARD_HEIGHT)-1:0] wr_y,
    input  logic                            wr_ready,
    output logic                            busy,
    output logic                            done,
    output logic [5:0]                      cells_written,
    output logic                            clipped
);
    localparam int XW = $clog2(BOARD_WIDTH);
    localparam int YW = $clog2(BOARD_HEIGHT);

    typedef enum logic [1:0] {StIdle, StScan, StWrite, StDone} state_e;

    state_e          state_q;
    logic [XW-1:0]   px_q;
    logic [YW-1:0]   py_q;
    logic [5:0][5:0] win_q;
    logic [2:0]      lx_q;
    logic [2:0]      ly_q;

    // Two extra bits: one for the -1 origin offset going negative, one for +5 overflow.
    logic [XW+1:0] wx;
    logic [YW+1:0] wy;
    logic          on_screen;
    logic          cell_set;
    logic          last_cell;

    always_comb begin
        wx        = (XW+2)'(px_q) + (XW+2)'(lx_q) - (XW+2)'(1);
        wy        = (YW+2)'(py_q) + (YW+2)'(ly_q) - (YW+2)'(1);
        on_screen = !wx[XW+1] && (wx[XW:0] < (XW+1)'(BOARD_WIDTH)) &&
                    !wy[YW+1] && (wy[YW:0] < (YW+1)'(BOARD_HEIGHT));
        cell_set  = win_q[lx_q][ly_q];
        last_cell = (lx_q == 3'd5) && (ly_q == 3'd5);
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            px_q          <= '0;
            py_q          <= '0;
            win_q         <= '0;
            lx_q          <= '0;
            ly_q          <= '0;
            wr_valid      <= 1'b0;
            wr_x          <= '0;
            wr_y          <= '0;
            done          <= 1'b0;
            cells_written <= '0;
            clipped       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        px_q          <= piece_x;
                        py_q          <= piece_y;
                        win_q         <= window;
                        lx_q          <= '0;
                        ly_q          <= '0;
                        cells_written <= '0;
                        clipped       <= 1'b0;
                        state_q       <= StScan;
                    end
                end
                StScan: begin
                    if (cell_set && on_screen) begin
                        wr_x     <= wx[XW-1:0];
                        wr_y     <= wy[YW-1:0];
                        wr_valid <= 1'b1;
                        state_q  <= StWrite;
                    end else begin
                        if (cell_set) begin
                            clipped <= 1'b1;
                        end
                        if (lx_q == 3'd5) begin
                            lx_q <= '0;
                            ly_q <= ly_q + 3'd1;
                        end else begin
                            lx_q <= lx_q + 3'd1;
                        end
                        if (last_cell) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (wr_ready) begin
                        wr_valid      <= 1'b0;
                        cells_written <= cells_written + 6'd1;
                        if (lx_q == 3'd5) begin
                            lx_q <= '0;
                            ly_q <= ly_q + 3'd1;
                        end else begin
                            lx_q <= lx_q + 3'd1;
                        end
                        if (last_cell) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StScan;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
